// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : memory_arbiter
// Purpose  : Fixed-priority, pipelined arbiter that places NUM_CH requesters
//            onto one synchronous memory port. Channel 0 has the highest
//            priority. Read data returns through a fixed-latency pipeline and
//            is steered back to the channel that issued the read.
// Options  : MEMORY_ARBITER_STARVATION_GUARD_EN - when defined, each channel
//            has a saturating wait counter. A channel at MAX_WAIT is urgent
//            and is served ahead of normal priority.
// Revision : 1.0 - initial release
//==============================================================================
module memory_arbiter #(
   parameter int NUM_CH      = 3,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int MEM_LATENCY = 1,
   parameter int MAX_WAIT    = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic [NUM_CH-1:0]        i_req,
   input  logic [NUM_CH-1:0]        i_we,
   input  logic [NUM_CH*ADDR_W-1:0] i_addr,
   input  logic [NUM_CH*DATA_W-1:0] i_wdata,
   output logic [NUM_CH-1:0]        o_ack,
   output logic [NUM_CH-1:0]        o_rvalid,
   output logic [DATA_W-1:0]        o_rdata,
   output logic                     o_mem_en,
   output logic                     o_mem_we,
   output logic [ADDR_W-1:0]        o_mem_addr,
   output logic [DATA_W-1:0]        o_mem_wdata,
   input  logic [DATA_W-1:0]        i_mem_rdata
);

   localparam int c_ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int c_DEPTH = MEM_LATENCY + 1;

   // Reject configurations outside the supported ranges at elaboration.
   if ((NUM_CH < 2) || (NUM_CH > 8) || (MEM_LATENCY < 1) || (MEM_LATENCY > 4) ||
       (MAX_WAIT < 1)) begin : g_cfg_check
      $error("memory_arbiter: unsupported parameter combination");
   end

   logic [NUM_CH-1:0] r_ack;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [NUM_CH-1:0] r_rvalid;
   logic [DATA_W-1:0] r_rdata;

   logic [c_DEPTH-1:0] r_pipe_v;
   logic [c_ID_W-1:0]  r_pipe_id [c_DEPTH];

   logic [NUM_CH-1:0] w_elig;
   logic [NUM_CH-1:0] w_cand;
   logic [NUM_CH-1:0] w_grant;
   logic              w_any;
   logic [c_ID_W-1:0] w_win_id;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   // A channel acked this cycle is masked so a held request is not issued twice.
   assign w_elig = i_req & ~r_ack;
   assign w_any  = |w_elig;

`ifdef MEMORY_ARBITER_STARVATION_GUARD_EN
   localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

   logic [NUM_CH-1:0] w_urgent;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_wait
      logic [c_WAIT_W-1:0] r_wait;

      assign w_urgent[g] = w_elig[g] && (r_wait == c_WAIT_W'(MAX_WAIT));

      // Count cycles a requesting channel is passed over; saturate at MAX_WAIT.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
         if (!i_reset_n) begin
            r_wait <= '0;
         end else if (!i_req[g] || r_ack[g] || w_grant[g]) begin
            r_wait <= '0;
         end else if (r_wait != c_WAIT_W'(MAX_WAIT)) begin
            r_wait <= r_wait + c_WAIT_W'(1);
         end
      end
   end

   // Urgent channels, when any are eligible, pre-empt normal priority.
   assign w_cand = (|w_urgent) ? w_urgent : w_elig;
`else
   assign w_cand = w_elig;
`endif

   // Pick the lowest-index candidate and mux its request fields.
   always_comb begin
      w_grant     = '0;
      w_win_id    = '0;
      w_sel_we    = 1'b0;
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (w_cand[c]) begin
            w_grant     = '0;
            w_grant[c]  = 1'b1;
            w_win_id    = c_ID_W'(c);
            w_sel_we    = i_we[c];
            w_sel_addr  = i_addr[c*ADDR_W +: ADDR_W];
            w_sel_wdata = i_wdata[c*DATA_W +: DATA_W];
         end
      end
   end

   // Issue stage: register the winner onto the memory port; address/data hold when idle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ack       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_ack    <= w_grant;
         r_mem_en <= w_any;
         r_mem_we <= w_any & w_sel_we;
         if (w_any) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
         end
      end
   end

   // Return pipeline: stage 0 aligns with the issue cycle; writes enter as invalid.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pipe_v <= '0;
         for (int i = 0; i < c_DEPTH; i++) begin
            r_pipe_id[i] <= '0;
         end
      end else begin
         r_pipe_v     <= {r_pipe_v[c_DEPTH-2:0], w_any & ~w_sel_we};
         r_pipe_id[0] <= w_win_id;
         for (int i = 1; i < c_DEPTH; i++) begin
            r_pipe_id[i] <= r_pipe_id[i-1];
         end
      end
   end

   // Capture memory data as a read leaves the pipeline and pulse its channel.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_rvalid <= '0;
         r_rdata  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_rvalid[c] <= r_pipe_v[c_DEPTH-1] && (r_pipe_id[c_DEPTH-1] == c_ID_W'(c));
         end
         if (r_pipe_v[c_DEPTH-1]) begin
            r_rdata <= i_mem_rdata;
         end
      end
   end

   assign o_ack       = r_ack;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_rvalid    = r_rvalid;
   assign o_rdata     = r_rdata;

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Parametrised, pipelined arbiter that multiplexes NUM_CH requesters (PPU, CPU, debug port, …) onto one synchronous memory port in the NES pixel-clock domain. Issues at most one access per cycle under fixed index priority (channel 0 highest), with an optional starvation guard. Tracks read data through a fixed-latency return pipeline and steers it back to the issuing channel.

## Interface
Parameters:
- NUM_CH, 3, number of requesters; channel 0 highest priority (0 = PPU, 1 = CPU, 2 = DEBUG in the NES top level); range 2..8
- ADDR_W, 16, address width
- DATA_W, 8, data width
- MEM_LATENCY, 1, cycles from o_mem_en to valid i_mem_rdata; range 1..4
- MAX_WAIT, 8, cycles a channel may be denied before becoming urgent (starvation guard only); ≥ 1

Ports:
- i_clk  in  1  pixel clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_req  in  NUM_CH  per-channel request level
- i_we  in  NUM_CH  per-channel write enable (1 = write)
- i_addr  in  NUM_CH*ADDR_W  packed addresses; channel c at [c*ADDR_W +: ADDR_W]
- i_wdata  in  NUM_CH*DATA_W  packed write data; same packing
- o_ack  out  NUM_CH  one-hot, one-cycle pulse: request accepted and issued
- o_rvalid  out  NUM_CH  one-hot, one-cycle pulse: o_rdata valid for that channel
- o_rdata  out  DATA_W  read data, shared by all channels
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after o_mem_en

## Operation
- Eligible set at each posedge: i_req & ~o_ack (channel acked in the current cycle is masked, so a held request is not issued twice).
- Winner: lowest-index eligible channel. At the edge, o_mem_* are registered from the winner's i_we/i_addr/i_wdata; o_ack[winner] = 1; o_mem_en = 1.
- No eligible channel: o_mem_en = 0, o_ack = 0; o_mem_addr/o_mem_wdata hold previous values; o_mem_we = 0.
- Requester holds i_we/i_addr/i_wdata stable while i_req is high and not yet acked; after seeing o_ack it deasserts i_req or presents the next request (next earliest grant is one cycle later).
- Read return: shift register of depth MEM_LATENCY+1 carrying {valid, channel id} for each read issue; writes enter as invalid. On exit, o_rdata <= i_mem_rdata and o_rvalid[id] pulses. Writes never produce o_rvalid.
- Pipeline fully overlapped: a new access may issue every cycle; read returns remain in issue order.
- Reset (asynchronous): every output 0 (o_ack, o_rvalid, o_rdata, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata); return pipeline and wait counters cleared. In-flight reads are discarded; no o_rvalid after reset deasserts unless a new read is issued.

## Timing
- Request sampled at edge E → o_ack and o_mem_* valid in cycle E+1 (one-cycle issue latency).
- Read issued in cycle T → i_mem_rdata sampled at end of cycle T+MEM_LATENCY → o_rvalid/o_rdata in cycle T+MEM_LATENCY+1.
- Same channel held continuously: one issue every 2 cycles. Two or more channels requesting: aggregate one issue per cycle.
- Simultaneous requests: lower index wins; the loser keeps waiting with its request held.

## Configuration
- MEMORY_ARBITER_STARVATION_GUARD_EN defined: per-channel counter of width $clog2(MAX_WAIT+1); increments when i_req & ~o_ack & not winner, saturates at MAX_WAIT, clears on ack or i_req low. Channels at MAX_WAIT are urgent; if any urgent channel is eligible, the winner is the lowest-index urgent channel, otherwise normal priority. Counters reset to 0.
- Undefined: pure fixed priority; no counters synthesised; lower channels may starve indefinitely.

## Test plan
- Reset: drive i_req=3'b111 with i_reset_n=0 → all outputs 0; deassert reset → first o_ack=3'b001 one cycle after first edge.
- Single read: ch1 read addr 0x2002, memory returns 0x5A with MEM_LATENCY=1 → o_ack=3'b010 in T, o_mem_addr=0x2002, o_mem_we=0, o_rvalid=3'b010 and o_rdata=0x5A in T+2.
- Priority and interleave: ch0, ch1 and ch2 each request continuously → ack sequence 001,010,001,010,…; ch2 never acked (guard undefined).
- Starvation guard (macro defined, MAX_WAIT=4): same stimulus → ch2 acked within 6 cycles of its first request; counter cleared afterwards.
- Write: ch2 writes 0xA5 to 0x07FF → o_mem_en=1, o_mem_we=1, o_mem_wdata=0xA5 for exactly 1 cycle; no o_rvalid pulses.
- Reset mid-read: issue ch0 read, assert i_reset_n=0 before return → o_rvalid stays 0 through and after reset.
